// File: rtl/snn_pkg.sv
// Shared SNN definitions used by the input queue and the network controller.
//   SR_DEPTH_DFLT : default synapse row count
//   NR_DEPTH_DFLT : default neuron count
//   syn_idx_t     : presynaptic (synapse row) index at the default row count
package snn_pkg;

    localparam int unsigned SR_DEPTH_DFLT = 16384;
    localparam int unsigned NR_DEPTH_DFLT = 256;

    typedef logic [$clog2(SR_DEPTH_DFLT)-1:0] syn_idx_t;

endpackage

// File: rtl/sync_fifo_2w1r.sv
// Circular buffer with two write ports and one read port.
// When both writes fire in one cycle, port A lands at wr_ptr and port B at wr_ptr+1.
// When only one fires, it lands at wr_ptr.
// The caller must never push more entries than the buffer has free, after counting the same-cycle pop.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   wr_a_en, wr_a_data     : first write port (lower address when both write)
//   wr_b_en, wr_b_data     : second write port
//   rd_en                  : pop the head (caller guarantees count != 0)
//   rd_data                : head entry, mem[rd_ptr]
//   count                  : occupancy, 0..DEPTH
module sync_fifo_2w1r #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_a_en,
    input  logic [WIDTH-1:0]         wr_a_data,
    input  logic                     wr_b_en,
    input  logic [WIDTH-1:0]         wr_b_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_p1 = wr_ptr_q + AW'(1);
        // DEPTH is a power of two, so pointer wrap is free in AW bits
        wr_ptr_d  = wr_ptr_q + AW'(wr_a_en) + AW'(wr_b_en);
        rd_ptr_d  = rd_ptr_q + AW'(rd_en);
        count_d   = count_q + CW'(wr_a_en) + CW'(wr_b_en) - CW'(rd_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (wr_a_en) begin
            mem[wr_ptr_q] <= wr_a_data;
        end
        if (wr_b_en) begin
            mem[wr_a_en ? wr_ptr_p1 : wr_ptr_q] <= wr_b_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/spike_input_queue.sv
// Merges external AER spikes (with backpressure) and recurrent on-chip spikes
// (no backpressure) into one FIFO that feeds the network controller.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   ext_valid/ext_index/ext_ready : external event handshake
//   rec_valid/rec_index        : recurrent event pulse; dropped if no room
//   input_occurred/input_index : FIFO head presented to the controller
//   input_ack                  : controller consumed the head
//   level                      : current occupancy
//   drop_count                 : saturating count of dropped recurrent events
//   err_ack_empty              : sticky flag, ack seen while empty
module spike_input_queue
    import snn_pkg::*;
#(
    parameter int unsigned SR_DEPTH   = SR_DEPTH_DFLT,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned IW        = $clog2(SR_DEPTH),
    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_valid,
    input  logic [IW-1:0]        ext_index,
    output logic                 ext_ready,
    input  logic                 rec_valid,
    input  logic [IW-1:0]        rec_index,
    output logic                 input_occurred,
    output logic [IW-1:0]        input_index,
    input  logic                 input_ack,
    output logic [LW-1:0]        level,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 err_ack_empty
);

    logic [LW-1:0]        count;
    logic                 pop, ext_push, rec_push, rec_drop;
    logic [CNT_WIDTH-1:0] drop_q;
    logic                 err_q;

    always_comb begin
        pop       = input_ack && (count != '0);
        // One slot is always held back so a recurrent spike can land even when
        // the external port pushes in the same cycle
        ext_ready = !reset && (count <= LW'(FIFO_DEPTH - 2));
        ext_push  = ext_valid && ext_ready;
        rec_push  = rec_valid && ((count < LW'(FIFO_DEPTH)) || pop);
        rec_drop  = rec_valid && !rec_push;
    end

    // Recurrent entry goes on port A so it is ordered ahead of the external one
    sync_fifo_2w1r #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_a_en   (rec_push),
        .wr_a_data (rec_index),
        .wr_b_en   (ext_push),
        .wr_b_data (ext_index),
        .rd_en     (pop),
        .rd_data   (input_index),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (rec_drop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_WIDTH'(1);
            end
            if (input_ack && (count == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign input_occurred = (count != '0);
    assign level          = count;
    assign drop_count     = drop_q;
    assign err_ack_empty  = err_q;

endmodule

// File: tb/tb_spike_input_queue.sv
// Randomised and directed stimulus for spike_input_queue, checked against a
// queue-based reference model of the acceptance/drop rules.
module tb_spike_input_queue;

    localparam int unsigned SR_DEPTH   = 16384;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned CNT_WIDTH  = 16;
    localparam int unsigned IW         = $clog2(SR_DEPTH);
    localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ext_valid = 1'b0;
    logic [IW-1:0]        ext_index = '0;
    logic                 ext_ready;
    logic                 rec_valid = 1'b0;
    logic [IW-1:0]        rec_index = '0;
    logic                 input_occurred;
    logic [IW-1:0]        input_index;
    logic                 input_ack = 1'b0;
    logic [LW-1:0]        level;
    logic [CNT_WIDTH-1:0] drop_count;
    logic                 err_ack_empty;

    spike_input_queue #(
        .SR_DEPTH   (SR_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ext_valid      (ext_valid),
        .ext_index      (ext_index),
        .ext_ready      (ext_ready),
        .rec_valid      (rec_valid),
        .rec_index      (rec_index),
        .input_occurred (input_occurred),
        .input_index    (input_index),
        .input_ack      (input_ack),
        .level          (level),
        .drop_count     (drop_count),
        .err_ack_empty  (err_ack_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    int mq[$];
    int mdrop = 0;
    bit merr  = 1'b0;
    localparam int DropMax = (1 << CNT_WIDTH) - 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz = mq.size();
        check_eq("occurred", 32'(input_occurred), 32'(sz != 0));
        if (sz != 0) check_eq("head_index", 32'(input_index), 32'(mq[0]));
        check_eq("level", 32'(level), 32'(sz));
        check_eq("ext_ready", 32'(ext_ready), 32'(sz <= FIFO_DEPTH - 2));
        check_eq("drop_count", 32'(drop_count), 32'(mdrop));
        check_eq("err_ack_empty", 32'(err_ack_empty), 32'(merr));
    endtask

    // Called at a negedge: check current state, drive inputs, advance model, run one clock.
    task automatic cycle(input bit ev, input int ei, input bit rv, input int ri, input bit ack);
        int  sz;
        bit  pop, room_ext, rp, ep;
        check_outputs();
        ext_valid = ev;
        ext_index = IW'(ei);
        rec_valid = rv;
        rec_index = IW'(ri);
        input_ack = ack;
        sz       = mq.size();
        pop      = ack && (sz != 0);
        room_ext = (sz <= FIFO_DEPTH - 2);
        rp       = rv && ((sz < FIFO_DEPTH) || pop);
        ep       = ev && room_ext;
        if (ack && sz == 0) merr = 1'b1;
        if (rv && !rp && mdrop < DropMax) mdrop++;
        if (pop) void'(mq.pop_front());
        if (rp) mq.push_back(ri);
        if (ep) mq.push_back(ei);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    function automatic int rnd_idx();
        return int'($urandom_range(0, SR_DEPTH - 1));
    endfunction

    initial begin
        // Reset state while reset is held
        #2;
        check_eq("rst_occurred", 32'(input_occurred), 32'd0);
        check_eq("rst_ext_ready", 32'(ext_ready), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        check_eq("rst_err", 32'(err_ack_empty), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single external event, then ack
        cycle(1'b1, 5, 1'b0, 0, 1'b0);
        check_eq("t1_occ", 32'(input_occurred), 32'd1);
        check_eq("t1_idx", 32'(input_index), 32'd5);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check_eq("t1_empty", 32'(input_occurred), 32'd0);
        idle();

        // Burst of 20 external events with no ack: only 15 accepted
        for (int i = 0; i < 20; i++) cycle(1'b1, 100 + i, 1'b0, 0, 1'b0);
        check_eq("t2_level", 32'(level), 32'd15);
        check_eq("t2_head", 32'(input_index), 32'd100);

        // Recurrent fills the reserved slot, then drops, then push+pop at full
        cycle(1'b0, 0, 1'b1, 9, 1'b0);
        check_eq("t3_full", 32'(level), 32'(FIFO_DEPTH));
        cycle(1'b0, 0, 1'b1, 11, 1'b0);
        check_eq("t3_drop", 32'(drop_count), 32'd1);
        check_eq("t3_head", 32'(input_index), 32'd100);
        cycle(1'b0, 0, 1'b1, 12, 1'b1);
        check_eq("t3_full2", 32'(level), 32'(FIFO_DEPTH));
        check_eq("t3_drop2", 32'(drop_count), 32'd1);
        for (int i = 0; i < FIFO_DEPTH; i++) cycle(1'b0, 0, 1'b0, 0, 1'b1);

        // Same-cycle dual push: recurrent first
        cycle(1'b1, 3, 1'b1, 7, 1'b0);
        check_eq("t4_level", 32'(level), 32'd2);
        check_eq("t4_head0", 32'(input_index), 32'd7);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check_eq("t4_head1", 32'(input_index), 32'd3);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);

        // Ack on empty queue sets sticky error
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check_eq("t5_err", 32'(err_ack_empty), 32'd1);
        idle();
        idle();

        // Async reset mid-burst at level 10
        for (int i = 0; i < 10; i++) cycle(1'b1, 300 + i, 1'b0, 0, 1'b0);
        check_eq("t6_pre_level", 32'(level), 32'd10);
        ext_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_occ", 32'(input_occurred), 32'd0);
        check_eq("t6_drop", 32'(drop_count), 32'd0);
        check_eq("t6_err", 32'(err_ack_empty), 32'd0);
        check_eq("t6_ready", 32'(ext_ready), 32'd0);
        mq.delete();
        mdrop = 0;
        merr  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Pointer wrap: 40 push/ack pairs
        for (int i = 0; i < 40; i++) cycle(1'b1, 200 + i, 1'b0, 0, i > 0);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check_eq("t7_empty", 32'(level), 32'd0);

        // Random traffic: congested then draining
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 70, rnd_idx(), $urandom_range(0, 99) < 40, rnd_idx(),
                  $urandom_range(0, 99) < 20);
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 40, rnd_idx(), $urandom_range(0, 99) < 25, rnd_idx(),
                  $urandom_range(0, 99) < 75);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
